// File: rtl/binary_search_pkg.sv
// Shared constants and writer state encoding for the binary-search block family.
package binary_search_pkg;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 32;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        FULL = 2'd1,
        ERR  = 2'd2
    } writer_state_e;

endpackage

// File: rtl/binary_ram_writer.sv
// Streams bytes into the 32x8 search RAM at consecutive addresses.
// Optional macro ORDER_CHECK_EN rejects bytes that break non-decreasing order.
module binary_ram_writer #(
    parameter int unsigned ADDR_W = binary_search_pkg::ADDR_W,
    parameter int unsigned DATA_W = binary_search_pkg::DATA_W
) (
    input  logic              CLOCK_50,
    input  logic              Reset,
    input  logic              clear,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data,
    output logic              wren,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              error
);
    import binary_search_pkg::*;

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned WORDS = 2 ** ADDR_W;

    writer_state_e     state_q, state_d;
    logic [ADDR_W-1:0] address_d;
    logic [DATA_W-1:0] data_d;
    logic              wren_d;
    logic [CNT_W-1:0]  count_d;
    logic              full_d;
    logic              accept_c;
    logic              in_order_c;

`ifdef ORDER_CHECK_EN
    logic [DATA_W-1:0] last_q, last_d;
    logic              last_valid_q, last_valid_d;
    logic              error_d;

    // First byte after reset/clear is always in order; equal values allowed.
    assign in_order_c = !last_valid_q || (in_data >= last_q);
`else
    assign in_order_c = 1'b1;
    assign error      = 1'b0;
`endif

    // Ready only while filling; clear blocks the handshake in its cycle.
    assign in_ready = (state_q == FILL) && !clear;
    assign accept_c = in_valid && in_ready;

    // Next state, RAM port and bookkeeping for the coming edge.
    always_comb begin
        state_d   = state_q;
        address_d = address;
        data_d    = data;
        wren_d    = 1'b0;
        count_d   = count;
`ifdef ORDER_CHECK_EN
        last_d       = last_q;
        last_valid_d = last_valid_q;
        error_d      = error;
`endif
        if (clear) begin
            state_d = FILL;
            count_d = '0;
`ifdef ORDER_CHECK_EN
            last_valid_d = 1'b0;
            error_d      = 1'b0;
`endif
        end else if (accept_c) begin
            if (in_order_c) begin
                address_d = count[ADDR_W-1:0];
                data_d    = in_data;
                wren_d    = 1'b1;
                count_d   = count + CNT_W'(1);
`ifdef ORDER_CHECK_EN
                last_d       = in_data;
                last_valid_d = 1'b1;
`endif
                if (count == CNT_W'(WORDS - 1)) begin
                    state_d = FULL;
                end
            end else begin
                // Out-of-order byte is consumed but never written.
                state_d = ERR;
`ifdef ORDER_CHECK_EN
                error_d = 1'b1;
`endif
            end
        end
        full_d = (state_d == FULL);
    end

    // State and registered outputs; reset takes effect immediately.
    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            state_q <= FILL;
            address <= '0;
            data    <= '0;
            wren    <= 1'b0;
            count   <= '0;
            full    <= 1'b0;
`ifdef ORDER_CHECK_EN
            last_q       <= '0;
            last_valid_q <= 1'b0;
            error        <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            address <= address_d;
            data    <= data_d;
            wren    <= wren_d;
            count   <= count_d;
            full    <= full_d;
`ifdef ORDER_CHECK_EN
            last_q       <= last_d;
            last_valid_q <= last_valid_d;
            error        <= error_d;
`endif
        end
    end

endmodule

// File: tb/tb_binary_ram_writer.sv
// Self-checking bench for binary_ram_writer: vector table, directed corner
// sequences and a random stream against a queue-based reference model.
module tb_binary_ram_writer;

    logic       CLOCK_50;
    logic       Reset;
    logic       clear;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] address;
    logic [7:0] data;
    logic       wren;
    logic [5:0] count;
    logic       full;
    logic       error;

    binary_ram_writer dut (
        .CLOCK_50 (CLOCK_50),
        .Reset    (Reset),
        .clear    (clear),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .address  (address),
        .data     (data),
        .wren     (wren),
        .count    (count),
        .full     (full),
        .error    (error)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    // RAM image as the real RAM would capture it.
    logic [7:0] tb_ram [32];
    always @(posedge CLOCK_50) begin
        if (wren) tb_ram[address] <= data;
    end

    int checks = 0;
    int errors = 0;

    // Reference model: bytes stored since the last reset/clear plus error flag.
    logic [7:0] stored[$];
    bit         m_err;
    bit         exp_wren;
    logic [4:0] exp_addr;
    logic [7:0] exp_data;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        stored.delete();
        m_err    = 1'b0;
        exp_wren = 1'b0;
        exp_addr = '0;
        exp_data = '0;
    endtask

    function automatic bit model_in_order(input logic [7:0] d);
`ifdef ORDER_CHECK_EN
        if (stored.size() == 0) return 1'b1;
        return d >= stored[stored.size()-1];
`else
        return 1'b1;
`endif
    endfunction

    // One clock cycle: drive, check ready, advance model, check registered outputs.
    task automatic cycle(input bit v, input logic [7:0] d, input bit clr);
        bit exp_ready;
        in_valid = v;
        in_data  = d;
        clear    = clr;
        #1;
        exp_ready = (stored.size() < 32) && !m_err && !clr;
        check("in_ready", int'(in_ready), int'(exp_ready));
        exp_wren = 1'b0;
        if (clr) begin
            stored.delete();
            m_err = 1'b0;
        end else if (v && exp_ready) begin
            if (model_in_order(d)) begin
                exp_addr = 5'(stored.size());
                exp_data = d;
                exp_wren = 1'b1;
                stored.push_back(d);
            end else begin
                m_err = 1'b1;
            end
        end
        @(posedge CLOCK_50);
        #1;
        check("wren", int'(wren), int'(exp_wren));
        check("address", int'(address), int'(exp_addr));
        check("data", int'(data), int'(exp_data));
        check("count", int'(count), stored.size());
        check("full", int'(full), int'(stored.size() == 32));
        check("error", int'(error), int'(m_err));
    endtask

    task automatic do_reset();
        @(negedge CLOCK_50);
        Reset    = 1'b1;
        in_valid = 1'b0;
        clear    = 1'b0;
        model_reset();
        @(negedge CLOCK_50);
        Reset = 1'b0;
    endtask

    typedef struct {
        bit         v;
        logic [7:0] d;
        bit         exp_wren;
        logic [4:0] exp_addr;
        logic [7:0] exp_data;
        int         exp_count;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [7:0] rd;
        vecs[0] = '{1'b1, 8'd10, 1'b1, 5'd0, 8'd10, 1};
        vecs[1] = '{1'b0, 8'd0,  1'b0, 5'd0, 8'd10, 1};
        vecs[2] = '{1'b1, 8'd20, 1'b1, 5'd1, 8'd20, 2};
        vecs[3] = '{1'b0, 8'd0,  1'b0, 5'd1, 8'd20, 2};
        vecs[4] = '{1'b1, 8'd30, 1'b1, 5'd2, 8'd30, 3};
        vecs[5] = '{1'b0, 8'd0,  1'b0, 5'd2, 8'd30, 3};

        Reset    = 1'b1;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        model_reset();

        // Reset values
        #12;
        check("rst_address", int'(address), 0);
        check("rst_data", int'(data), 0);
        check("rst_wren", int'(wren), 0);
        check("rst_count", int'(count), 0);
        check("rst_full", int'(full), 0);
        check("rst_error", int'(error), 0);
        check("rst_in_ready", int'(in_ready), 1);
        @(negedge CLOCK_50);
        Reset = 1'b0;

        // Continuous fill 0..31
        for (int i = 0; i < 32; i++) begin
            cycle(1'b1, 8'(i), 1'b0);
            check("fill_wren", int'(wren), 1);
            check("fill_addr", int'(address), i);
        end
        check("full_count", int'(count), 32);
        check("full_flag", int'(full), 1);
        check("full_ready", int'(in_ready), 0);
        cycle(1'b1, 8'd99, 1'b0);
        check("byte33_wren", int'(wren), 0);
        check("byte33_count", int'(count), 32);
        for (int i = 0; i < 32; i++) check("ram_fill", int'(tb_ram[i]), i);

        // Sparse stream from the vector table
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(vecs[i].v, vecs[i].d, 1'b0);
            check("vec_wren", int'(wren), int'(vecs[i].exp_wren));
            check("vec_addr", int'(address), int'(vecs[i].exp_addr));
            check("vec_data", int'(data), int'(vecs[i].exp_data));
            check("vec_count", int'(count), vecs[i].exp_count);
        end

        // Order check sequence
        do_reset();
`ifdef ORDER_CHECK_EN
        cycle(1'b1, 8'd5, 1'b0);
        cycle(1'b1, 8'd9, 1'b0);
        cycle(1'b1, 8'd9, 1'b0);
        cycle(1'b1, 8'd4, 1'b0);
        check("ooo_wren", int'(wren), 0);
        cycle(1'b1, 8'd7, 1'b0);
        check("err_flag", int'(error), 1);
        check("err_count", int'(count), 3);
        check("err_ready", int'(in_ready), 0);
        cycle(1'b0, 8'd0, 1'b1);
        cycle(1'b1, 8'd200, 1'b0);
        cycle(1'b1, 8'd201, 1'b0);
        check("recover_err", int'(error), 0);
        check("recover_count", int'(count), 2);
        check("recover_addr", int'(address), 1);
        check("recover_data", int'(data), 201);
`else
        cycle(1'b1, 8'd9, 1'b0);
        cycle(1'b1, 8'd3, 1'b0);
        check("nochk_wren", int'(wren), 1);
        check("nochk_data", int'(data), 3);
        check("nochk_count", int'(count), 2);
        check("nochk_err", int'(error), 0);
`endif

        // clear together with valid at count 12
        do_reset();
        for (int i = 0; i < 12; i++) cycle(1'b1, 8'(i * 3), 1'b0);
        check("pre_clear_count", int'(count), 12);
        cycle(1'b1, 8'd250, 1'b1);
        check("clear_wren", int'(wren), 0);
        check("clear_count", int'(count), 0);

        // Asynchronous reset during a wren pulse
        do_reset();
        cycle(1'b1, 8'h55, 1'b0);
        check("pre_rst_wren", int'(wren), 1);
        #2;
        Reset = 1'b1;
        #1;
        check("async_wren", int'(wren), 0);
        check("async_count", int'(count), 0);
        model_reset();
        in_valid = 1'b0;
        @(negedge CLOCK_50);
        Reset = 1'b0;
        cycle(1'b1, 8'h66, 1'b0);
        check("post_rst_addr", int'(address), 0);
        check("post_rst_data", int'(data), 8'h66);

        // Random stream against the model
        do_reset();
        rd = 8'd0;
        for (int n = 0; n < 400; n++) begin
            bit v;
            bit clr;
            v   = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 5) == 0) rd = 8'($urandom_range(0, 255));
            else rd = 8'(rd + 8'($urandom_range(0, 4)));
            cycle(v, rd, clr);
        end
        cycle(1'b0, 8'd0, 1'b0);
        for (int i = 0; i < stored.size(); i++) check("ram_random", int'(tb_ram[i]), int'(stored[i]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/binary_ram_writer.md
# binary_ram_writer

Loader for the 32×8 single-port RAM that the binary-search datapath reads. It accepts bytes over a valid/ready stream and writes them to consecutive addresses 0..31. It reports the fill count and a full flag. Optionally, it rejects bytes that would break the ascending order the search depends on. It drives the RAM's address/data/wren port while the search datapath is idle; the parent muxes the RAM port between the two blocks.

## Interface
Parameters:
- ADDR_W, 5, RAM address width; depth = 2**ADDR_W (32)
- DATA_W, 8, RAM word width

Ports:
- CLOCK_50  in  1  sole clock; all state updates on the rising edge
- Reset  in  1  asynchronous, active-high; clears all state immediately
- clear  in  1  synchronous restart of a fill; count returns to 0
- in_data  in  DATA_W  byte to store
- in_valid  in  1  in_data is valid this cycle
- in_ready  out  1  block will accept in_data this cycle
- address  out  ADDR_W  RAM address
- data  out  DATA_W  RAM write data
- wren  out  1  RAM write enable, one-cycle pulse per stored byte
- count  out  ADDR_W+1  number of bytes stored (0..32)
- full  out  1  count == 32
- error  out  1  order violation latched (ORDER_CHECK_EN only)

## Operation
- States: FILL, FULL, ERR. Reset enters FILL.
- in_ready = (state == FILL) && !clear. This is combinational.
- A byte is accepted on a cycle where in_valid && in_ready.
- On accept in FILL, if the byte is in order (or the check is disabled):
  - register address <= count[ADDR_W-1:0], data <= in_data, wren <= 1;
  - count <= count + 1;
  - last <= in_data.
- No accept in a cycle → wren <= 0. address and data hold their values.
- Transition to FULL occurs on the accept that makes count 32. In FULL, in_ready = 0 and further in_valid is ignored.
- Order check (macro on): the first byte after reset or clear is always in order. A later byte is out of order when in_data < last; equal values are allowed.
- An out-of-order byte is consumed (handshake completes) but is not written: wren stays 0, count is unchanged, state goes to ERR, and error <= 1.
- In ERR, in_ready = 0 until clear.
- clear in any state: state → FILL, count 0, full 0, error 0, wren 0, last-valid flag cleared. clear wins over a simultaneous in_valid, because in_ready is 0.
- full = (state == FULL) and is registered with the state.

## Timing
- Reset values: address 0, data 0, wren 0, count 0, full 0, error 0, state FILL.
- in_ready reads 1 out of reset when clear is low.
- Write latency is 1 cycle: a byte accepted at edge N produces wren/address/data valid during cycle N+1 and is sampled by the RAM at edge N+1.
- Throughput is one byte per cycle. With a continuous stream, wren stays high for 32 consecutive cycles.
- count and full update at the same edge as the accept. full is 1 in the cycle after the 32nd accept, while that byte's wren is still high.
- count wraps: no. Address 31 is the last one written, and count saturates at 32 through the FULL state.
- Reset mid-fill: wren drops asynchronously. A partially written RAM is left as is, and the fill restarts at address 0.

## Configuration
- ORDER_CHECK_EN defined: the non-decreasing check, ERR state, last register and error output are active as described above.
- ORDER_CHECK_EN undefined: every valid byte is written, ERR is unreachable, and error is tied to 0.

## Structure
- Shared package binary_search_pkg holds:
  - ADDR_W = 5, DATA_W = 8, DEPTH = 32;
  - the writer state enum (FILL, FULL, ERR).
  The search datapath and controller use the same constants from this package.
- Single module with no sub-module. The RAM_32_8_1port instance and the port mux stay in the parent.

## Test plan
- Reset, then stream 0,1,…,31 with in_valid held high → 32 consecutive wren pulses at addresses 0..31 with data = address. count reads 32, full reads 1, in_ready reads 0. A 33rd valid byte produces no wren.
- Sparse stream: in_valid toggled every other cycle with bytes 10,20,30 → exactly 3 wren pulses, each one cycle after its accept; address/data hold between pulses; count = 3.
- Macro on, stream 5,9,9,4,7 → bytes 5,9,9 written at addresses 0..2. The 4 is consumed but not written, error = 1, in_ready = 0, the 7 is not accepted, count = 3.
- From ERR, assert clear for 1 cycle, then stream 200,201 → error = 0, writes at addresses 0 and 1, count = 2.
- Assert clear and in_valid together mid-fill at count = 12 → in_ready = 0 that cycle, no wren, count = 0 next cycle.
- Assert Reset asynchronously mid-cycle during a wren pulse → wren and count go to 0 before the next edge. After release, the first byte writes to address 0.
- Macro off, stream 9,3 → both written, error stays 0.
